// File: rtl/nios_onchip_ram_if.sv
// Avalon-MM slave bus and sideband controls for nios_onchip_ram_pipelined.
interface nios_onchip_ram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] address;
   logic [BE_WIDTH-1:0]   byteenable;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic                  reset_req;
   logic                  clken;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  readdatavalid;
   logic                  waitrequest;
   logic                  addr_err;

   modport master (
      output address, byteenable, chipselect, read, write, writedata,
             reset_req, clken, err_clr,
      input  readdata, readdatavalid, waitrequest, addr_err
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata,
             reset_req, clken, err_clr,
      output readdata, readdatavalid, waitrequest, addr_err
   );
endinterface

// File: rtl/nios_onchip_ram_pipelined.sv
// Single-port Avalon-MM on-chip RAM with optional output register and sticky address error.
// Define NIOS_ONCHIP_RAM_CLEAR_EN to add the clear-on-reset engine.
module nios_onchip_ram_pipelined #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int DEPTH      = 87500,
   parameter int OUT_REG    = 0,
   parameter     INIT_FILE  = "Nios_display_system_onchip_memory2_0.hex"
) (
   input logic              clk,
   input logic              reset,
   nios_onchip_ram_if.slave s_bus
);
   localparam int BE_WIDTH     = DATA_WIDTH / 8;
   localparam int READ_LATENCY = 1 + OUT_REG;
   localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   // The power-up image is bound to the array through the RAM-init attribute.
   (* ram_init_file = INIT_FILE *)
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_clearing;
   logic                  w_waitrequest;
   logic                  w_accept;
   logic                  w_in_range;
   logic                  w_rd_issue;
   logic                  w_wr_do;
   logic                  w_err_set;
   logic [IDX_W-1:0]      w_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  w_mem_we;
   logic [IDX_W-1:0]      w_mem_idx;
   logic [BE_WIDTH-1:0]   w_mem_be;
   logic [DATA_WIDTH-1:0] w_mem_wdata;

   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_addr_err;

   assign w_waitrequest = reset | s_bus.reset_req | ~s_bus.clken | w_clearing;
   assign w_accept      = s_bus.chipselect & (s_bus.read | s_bus.write) & ~w_waitrequest;
   assign w_in_range    = ({1'b0, s_bus.address} < DEPTH_W);
   assign w_idx         = s_bus.address[IDX_W-1:0];
   // A combined read+write performs only the write and is flagged as a protocol error.
   assign w_rd_issue    = w_accept & s_bus.read & ~s_bus.write;
   assign w_wr_do       = w_accept & s_bus.write & w_in_range;
   assign w_err_set     = w_accept & (~w_in_range | (s_bus.read & s_bus.write));
   assign w_rd_word     = w_in_range ? r_mem[w_idx] : '0;

`ifdef NIOS_ONCHIP_RAM_CLEAR_EN
   typedef enum logic {CLEAR, READY} clr_state_t;

   clr_state_t       r_state;
   logic [IDX_W-1:0] r_clr_ptr;
   logic             w_clr_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= CLEAR;
         r_clr_ptr <= '0;
      end else if (s_bus.clken && r_state == CLEAR) begin
         if (r_clr_ptr == IDX_W'(DEPTH - 1)) r_state <= READY;
         r_clr_ptr <= r_clr_ptr + IDX_W'(1);
      end
   end

   assign w_clearing  = (r_state == CLEAR);
   assign w_clr_we    = w_clearing & s_bus.clken & ~reset;
   assign w_mem_we    = w_clr_we | w_wr_do;
   assign w_mem_idx   = w_clr_we ? r_clr_ptr : w_idx;
   assign w_mem_be    = w_clr_we ? '1 : s_bus.byteenable;
   assign w_mem_wdata = w_clr_we ? '0 : s_bus.writedata;
`else
   assign w_clearing  = 1'b0;
   assign w_mem_we    = w_wr_do;
   assign w_mem_idx   = w_idx;
   assign w_mem_be    = s_bus.byteenable;
   assign w_mem_wdata = s_bus.writedata;
`endif

   // NOTE: the array has no reset branch; a reset term would stop it mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (w_mem_be[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_addr_err <= 1'b0;
      end else if (s_bus.clken) begin
         r_rd_valid <= w_rd_issue;
         if (w_rd_issue) r_rd_data <= w_rd_word;
         if (w_err_set)          r_addr_err <= 1'b1;
         else if (s_bus.err_clr) r_addr_err <= 1'b0;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_out_reg
         logic                  r_out_valid;
         logic [DATA_WIDTH-1:0] r_out_data;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_out_valid <= 1'b0;
               r_out_data  <= '0;
            end else if (s_bus.clken) begin
               r_out_valid <= r_rd_valid;
               if (r_rd_valid) r_out_data <= r_rd_data;
            end
         end

         assign s_bus.readdata      = r_out_data;
         assign s_bus.readdatavalid = r_out_valid;
      end else begin : g_no_out_reg
         assign s_bus.readdata      = r_rd_data;
         assign s_bus.readdatavalid = r_rd_valid;
      end
   endgenerate

   assign s_bus.waitrequest = w_waitrequest;
   assign s_bus.addr_err    = r_addr_err;
endmodule
